// File: rtl/lfsr_rng_pkg.sv
// Shared types and helpers for the lfsr_rng random-number generator.
// Holds the FSM state encoding, the width limit for delivered values and
// a table of maximal-length XNOR tap masks.
package lfsr_rng_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } rng_state_t;

    localparam int OUT_W_MAX = 32;

    // Maximal-length tap masks for an XNOR LFSR that shifts towards the MSB
    // and feeds bit 0. Bit i of the mask selects state[i]. Widths outside
    // 3..32 return zero.
    function automatic logic [31:0] default_taps(input int width);
        logic [31:0] taps;
        case (width)
            3:       taps = 32'h0000_0006;
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0829;
            13:      taps = 32'h0000_100D;
            14:      taps = 32'h0000_2015;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_D008;
            17:      taps = 32'h0001_2000;
            18:      taps = 32'h0002_0400;
            19:      taps = 32'h0004_0023;
            20:      taps = 32'h0009_0000;
            21:      taps = 32'h0014_0000;
            22:      taps = 32'h0030_0000;
            23:      taps = 32'h0042_0000;
            24:      taps = 32'h00E1_0000;
            25:      taps = 32'h0120_0000;
            26:      taps = 32'h0200_0023;
            27:      taps = 32'h0400_0013;
            28:      taps = 32'h0900_0000;
            29:      taps = 32'h1400_0000;
            30:      taps = 32'h2000_0029;
            31:      taps = 32'h4800_0000;
            32:      taps = 32'h8020_0003;
            default: taps = 32'h0000_0000;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/lfsr_rng_if.sv
// Request/acknowledge bundle between a consumer and lfsr_rng.
// The master side is the consumer (game-question logic); the slave side
// is the generator itself.
interface lfsr_rng_if #(
    parameter int WIDTH = 8,
    parameter int OUT_W = 4
);

    logic             seed_load;
    logic [WIDTH-1:0] seed_in;
    logic             free_run;
    logic             req;
    logic [OUT_W-1:0] limit;
    logic             rnd_valid;
    logic [OUT_W-1:0] rnd_out;
    logic             rnd_ack;
    logic             busy;
    logic             timeout;

    modport master (
        output seed_load, seed_in, free_run, req, limit, rnd_ack,
        input  rnd_valid, rnd_out, busy, timeout
    );

    modport slave (
        input  seed_load, seed_in, free_run, req, limit, rnd_ack,
        output rnd_valid, rnd_out, busy, timeout
    );

endinterface

// File: rtl/lfsr_rng_core.sv
// XNOR-feedback LFSR used by lfsr_rng.
// Handles seed loading, stepping and recovery from the all-ones lockup
// state; exposes only the low OUT_W bits as the candidate value.
module lfsr_core
    import lfsr_rng_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               OUT_W = 4,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             step,
    output logic [OUT_W-1:0] cand
);

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] lfsr_d;
    logic             fb;

    assign lfsr = lfsr_q;
    assign fb   = ~^(lfsr & TAPS);
    assign cand = lfsr[OUT_W-1:0];

    // Next state: a seed load wins over a step, and all-ones (the XNOR
    // lockup value) is never loaded or stepped from; SEED replaces it.
    always_comb begin
        lfsr_d = lfsr;
        if (load) begin
            lfsr_d = (&seed_in) ? SEED : seed_in;
        end else if (step) begin
            lfsr_d = (&lfsr) ? SEED : {lfsr[WIDTH-2:0], fb};
        end
    end

    // State register, returns to SEED on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/lfsr_rng.sv
// Bounded-range random-number generator: an LFSR feeds candidates to a
// rejection-sampling FSM that delivers a value in [0, limit] over a
// request/acknowledge port. If no candidate fits within MAX_TRIES
// attempts a fallback value is delivered and timeout pulses.
// Optional feature: define NO_REPEAT_EN to also reject a candidate equal
// to the previously delivered value.
module lfsr_rng
    import lfsr_rng_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED      = '0,
    parameter int               OUT_W     = 4,
    parameter int               MAX_TRIES = 16
) (
    input  logic       clk,
    input  logic       rst,
    lfsr_rng_if.slave  bus
);

    localparam int                 TRIES_W  = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRIES_W-1:0] LAST_TRY = TRIES_W'(MAX_TRIES - 1);

    rng_state_t         state_q;
    rng_state_t         state_d;
    logic [TRIES_W-1:0] tries_q;
    logic [TRIES_W-1:0] tries_d;
    logic [OUT_W-1:0]   limit_q;
    logic [OUT_W-1:0]   limit_d;
    logic [OUT_W-1:0]   rnd_out_q;
    logic [OUT_W-1:0]   rnd_out_d;
    logic               rnd_valid_q;
    logic               rnd_valid_d;
    logic               timeout_q;
    logic               timeout_d;
    logic [OUT_W-1:0]   cand;
    logic [OUT_W-1:0]   fallback;
    logic               accept;
    logic               step;
`ifdef NO_REPEAT_EN
    logic [OUT_W-1:0]   last_q;
    logic [OUT_W-1:0]   last_d;
`endif

    // The LFSR runs every cycle while searching so each attempt sees a
    // fresh candidate; otherwise it only moves when free-running.
    assign step = (state_q == SEARCH) || bus.free_run;

    lfsr_core #(
        .WIDTH (WIDTH),
        .OUT_W (OUT_W),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (bus.seed_load),
        .seed_in (bus.seed_in),
        .step    (step),
        .cand    (cand)
    );

    // Candidate acceptance and the value used when the search gives up.
    always_comb begin
`ifdef NO_REPEAT_EN
        accept   = (cand <= limit_q) && ((cand != last_q) || (limit_q == '0));
        fallback = ((last_q == '0) && (limit_q != '0)) ? OUT_W'(1) : '0;
`else
        accept   = (cand <= limit_q);
        fallback = '0;
`endif
    end

    // Request FSM: latch the bound, search for a fitting candidate, then
    // hold the result until the consumer acknowledges it.
    always_comb begin
        state_d     = state_q;
        tries_d     = tries_q;
        limit_d     = limit_q;
        rnd_out_d   = rnd_out_q;
        rnd_valid_d = 1'b0;
        timeout_d   = 1'b0;
`ifdef NO_REPEAT_EN
        last_d      = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    limit_d = bus.limit;
                    tries_d = '0;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (accept) begin
                    rnd_out_d   = cand;
                    rnd_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (tries_q == LAST_TRY) begin
                    rnd_out_d   = fallback;
                    rnd_valid_d = 1'b1;
                    timeout_d   = 1'b1;
                    state_d     = DONE;
                end else begin
                    tries_d = tries_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.rnd_ack) begin
                    state_d = IDLE;
`ifdef NO_REPEAT_EN
                    last_d  = rnd_out_q;
`endif
                end else begin
                    rnd_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and result registers, cleared asynchronously so a pending
    // request is dropped the moment reset is asserted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            tries_q     <= '0;
            limit_q     <= '0;
            rnd_out_q   <= '0;
            rnd_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tries_q     <= tries_d;
            limit_q     <= limit_d;
            rnd_out_q   <= rnd_out_d;
            rnd_valid_q <= rnd_valid_d;
            timeout_q   <= timeout_d;
        end
    end

`ifdef NO_REPEAT_EN
    // History of the last acknowledged value, used to avoid repeats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= '0;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign bus.rnd_valid = rnd_valid_q;
    assign bus.rnd_out   = rnd_out_q;
    assign bus.timeout   = timeout_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lfsr_rng.sv
// Directed testbench for lfsr_rng. Three instances share clock and reset:
// a 4-bit LFSR for sequence/lockup checks, an 8-bit generator with the
// default parameters, and an 8-bit generator with MAX_TRIES=2 for the
// fallback path. Inputs are driven and outputs sampled on the falling edge.
module tb_lfsr_rng;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    logic [3:0] seq4 [15] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6,
                              4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8};

    lfsr_rng_if #(.WIDTH(4), .OUT_W(4)) bus4 ();
    lfsr_rng_if #(.WIDTH(8), .OUT_W(4)) bus8 ();
    lfsr_rng_if #(.WIDTH(8), .OUT_W(4)) bus8t ();

    lfsr_rng #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h0), .OUT_W(4), .MAX_TRIES(16))
        dut4 (.clk(clk), .rst(rst), .bus(bus4));
    lfsr_rng #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h00), .OUT_W(4), .MAX_TRIES(16))
        dut8 (.clk(clk), .rst(rst), .bus(bus8));
    lfsr_rng #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h00), .OUT_W(4), .MAX_TRIES(2))
        dut8t (.clk(clk), .rst(rst), .bus(bus8t));

    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus4.seed_load = 0;  bus4.seed_in = '0;  bus4.free_run = 0;
        bus4.req = 0;        bus4.limit = '0;    bus4.rnd_ack = 0;
        bus8.seed_load = 0;  bus8.seed_in = '0;  bus8.free_run = 0;
        bus8.req = 0;        bus8.limit = '0;    bus8.rnd_ack = 0;
        bus8t.seed_load = 0; bus8t.seed_in = '0; bus8t.free_run = 0;
        bus8t.req = 0;       bus8t.limit = '0;   bus8t.rnd_ack = 0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        clear_inputs();
        rst = 0;
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (bus8.busy !== 1'b0 || bus8.rnd_valid !== 1'b0 || bus8.timeout !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got busy=%b valid=%b timeout=%b, want 0 0 0",
                     bus8.busy, bus8.rnd_valid, bus8.timeout);
        end
        vectors++;
        if (bus8.rnd_out !== 4'h0 || dut8.u_core.lfsr_q !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_values: got rnd_out=%h lfsr=%h, want 0 00",
                     bus8.rnd_out, dut8.u_core.lfsr_q);
        end
        rst = 1;
    endtask

    task automatic test_period();
        @(negedge clk);
        rst = 0;
        bus4.free_run = 1;
        @(negedge clk);
        rst = 1;
        vectors++;
        if (dut4.u_core.lfsr_q !== seq4[0]) begin
            miscompares++;
            $display("[TB] FAIL period_0: got %h expected %h", dut4.u_core.lfsr_q, seq4[0]);
        end
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            vectors++;
            if (dut4.u_core.lfsr_q !== seq4[i % 15]) begin
                miscompares++;
                $display("[TB] FAIL period_%0d: got %h expected %h", i, dut4.u_core.lfsr_q, seq4[i % 15]);
            end
        end
        bus4.free_run = 0;
    endtask

    task automatic test_lockup();
        pulse_reset();
        bus4.seed_in = 4'h5;
        bus4.seed_load = 1;
        @(negedge clk);
        bus4.seed_load = 0;
        vectors++;
        if (dut4.u_core.lfsr_q !== 4'h5) begin
            miscompares++;
            $display("[TB] FAIL seed_load: got %h expected 5", dut4.u_core.lfsr_q);
        end
        bus4.seed_in = 4'hF;
        bus4.seed_load = 1;
        @(negedge clk);
        bus4.seed_load = 0;
        vectors++;
        if (dut4.u_core.lfsr_q !== 4'h0) begin
            miscompares++;
            $display("[TB] FAIL seed_all_ones: got %h expected 0", dut4.u_core.lfsr_q);
        end
        bus4.seed_in = 4'h9;
        bus4.seed_load = 1;
        bus4.free_run = 1;
        @(negedge clk);
        bus4.seed_load = 0;
        vectors++;
        if (dut4.u_core.lfsr_q !== 4'h9) begin
            miscompares++;
            $display("[TB] FAIL load_over_step: got %h expected 9", dut4.u_core.lfsr_q);
        end
        force dut4.u_core.lfsr = 4'hF;
        @(negedge clk);
        release dut4.u_core.lfsr;
        bus4.free_run = 0;
        vectors++;
        if (dut4.u_core.lfsr_q !== 4'h0) begin
            miscompares++;
            $display("[TB] FAIL lockup_recover: got %h expected 0", dut4.u_core.lfsr_q);
        end
        @(negedge clk);
        vectors++;
        if (dut4.u_core.lfsr_q !== 4'h0) begin
            miscompares++;
            $display("[TB] FAIL hold_no_free_run: got %h expected 0", dut4.u_core.lfsr_q);
        end
    endtask

    task automatic test_basic();
        pulse_reset();
        bus8.seed_in = 8'h5A;
        bus8.seed_load = 1;
        @(negedge clk);
        bus8.seed_load = 0;
        bus8.limit = 4'hF;
        bus8.req = 1;
        @(negedge clk);
        bus8.req = 0;
        bus8.limit = 4'h0;
        vectors++;
        if (bus8.busy !== 1'b1 || bus8.rnd_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_search: got busy=%b valid=%b, want 1 0", bus8.busy, bus8.rnd_valid);
        end
        @(negedge clk);
        vectors++;
        if (bus8.rnd_valid !== 1'b1 || bus8.rnd_out !== 4'hA || bus8.timeout !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_deliver: got valid=%b out=%h timeout=%b, want 1 a 0",
                     bus8.rnd_valid, bus8.rnd_out, bus8.timeout);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (bus8.rnd_valid !== 1'b1 || bus8.rnd_out !== 4'hA) begin
                miscompares++;
                $display("[TB] FAIL basic_hold_%0d: got valid=%b out=%h, want 1 a", i, bus8.rnd_valid, bus8.rnd_out);
            end
        end
        bus8.rnd_ack = 1;
        @(negedge clk);
        bus8.rnd_ack = 0;
        vectors++;
        if (bus8.rnd_valid !== 1'b0 || bus8.busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_ack: got valid=%b busy=%b, want 0 0", bus8.rnd_valid, bus8.busy);
        end
    endtask

    task automatic test_reject();
        pulse_reset();
        bus8.seed_in = 8'h5A;
        bus8.seed_load = 1;
        @(negedge clk);
        bus8.seed_load = 0;
        bus8.limit = 4'h5;
        bus8.req = 1;
        @(negedge clk);
        bus8.req = 0;
        @(negedge clk);
        vectors++;
        if (bus8.rnd_valid !== 1'b0 || bus8.busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reject_first: got valid=%b busy=%b, want 0 1", bus8.rnd_valid, bus8.busy);
        end
        @(negedge clk);
        vectors++;
        if (bus8.rnd_valid !== 1'b1 || bus8.rnd_out !== 4'h5 || bus8.timeout !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reject_second: got valid=%b out=%h timeout=%b, want 1 5 0",
                     bus8.rnd_valid, bus8.rnd_out, bus8.timeout);
        end
        bus8.rnd_ack = 1;
        @(negedge clk);
        bus8.rnd_ack = 0;
    endtask

    task automatic test_timeout();
        pulse_reset();
        bus8t.seed_in = 8'h5A;
        bus8t.seed_load = 1;
        @(negedge clk);
        bus8t.seed_load = 0;
        bus8t.limit = 4'h0;
        bus8t.req = 1;
        @(negedge clk);
        bus8t.req = 0;
        @(negedge clk);
        vectors++;
        if (bus8t.rnd_valid !== 1'b0 || bus8t.timeout !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL timeout_early: got valid=%b timeout=%b, want 0 0", bus8t.rnd_valid, bus8t.timeout);
        end
        @(negedge clk);
        vectors++;
        if (bus8t.rnd_valid !== 1'b1 || bus8t.timeout !== 1'b1 || bus8t.rnd_out !== 4'h0) begin
            miscompares++;
            $display("[TB] FAIL timeout_pulse: got valid=%b timeout=%b out=%h, want 1 1 0",
                     bus8t.rnd_valid, bus8t.timeout, bus8t.rnd_out);
        end
        @(negedge clk);
        vectors++;
        if (bus8t.rnd_valid !== 1'b1 || bus8t.timeout !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL timeout_one_cycle: got valid=%b timeout=%b, want 1 0", bus8t.rnd_valid, bus8t.timeout);
        end
        bus8t.rnd_ack = 1;
        @(negedge clk);
        bus8t.rnd_ack = 0;
        vectors++;
        if (bus8t.rnd_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL timeout_ack: got valid=%b, want 0", bus8t.rnd_valid);
        end
    endtask

    task automatic test_reset_mid_search();
        pulse_reset();
        bus8.seed_in = 8'h5A;
        bus8.seed_load = 1;
        @(negedge clk);
        bus8.seed_load = 0;
        bus8.limit = 4'h0;
        bus8.req = 1;
        @(negedge clk);
        bus8.req = 0;
        @(negedge clk);
        vectors++;
        if (bus8.busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midsearch_busy: got %b expected 1", bus8.busy);
        end
        #2;
        rst = 0;
        #1;
        vectors++;
        if (bus8.busy !== 1'b0 || bus8.rnd_valid !== 1'b0 || dut8.u_core.lfsr_q !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got busy=%b valid=%b lfsr=%h, want 0 0 00",
                     bus8.busy, bus8.rnd_valid, dut8.u_core.lfsr_q);
        end
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        vectors++;
        if (bus8.busy !== 1'b0 || bus8.rnd_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL request_dropped: got busy=%b valid=%b, want 0 0", bus8.busy, bus8.rnd_valid);
        end
    endtask

    task automatic test_req_in_done();
        pulse_reset();
        bus8.seed_in = 8'h5A;
        bus8.seed_load = 1;
        @(negedge clk);
        bus8.seed_load = 0;
        bus8.limit = 4'hF;
        bus8.req = 1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (bus8.rnd_valid !== 1'b1 || bus8.busy !== 1'b1 || bus8.rnd_out !== 4'hA) begin
            miscompares++;
            $display("[TB] FAIL done_req_ignored: got valid=%b busy=%b out=%h, want 1 1 a",
                     bus8.rnd_valid, bus8.busy, bus8.rnd_out);
        end
        bus8.rnd_ack = 1;
        @(negedge clk);
        bus8.rnd_ack = 0;
        vectors++;
        if (bus8.busy !== 1'b0 || bus8.rnd_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ack_with_req: got busy=%b valid=%b, want 0 0", bus8.busy, bus8.rnd_valid);
        end
        @(negedge clk);
        bus8.req = 0;
        vectors++;
        if (bus8.busy !== 1'b1 || bus8.rnd_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL back_to_back_accept: got busy=%b valid=%b, want 1 0", bus8.busy, bus8.rnd_valid);
        end
        @(negedge clk);
        vectors++;
        if (bus8.rnd_valid !== 1'b1 || bus8.rnd_out !== 4'h5) begin
            miscompares++;
            $display("[TB] FAIL back_to_back_value: got valid=%b out=%h, want 1 5", bus8.rnd_valid, bus8.rnd_out);
        end
        bus8.rnd_ack = 1;
        @(negedge clk);
        bus8.rnd_ack = 0;
    endtask

`ifdef NO_REPEAT_EN
    task automatic test_no_repeat();
        logic [3:0] want;
        pulse_reset();
        bus8.free_run = 1;
        bus8.limit = 4'h1;
        for (int k = 0; k < 20; k++) begin
            want = (k % 2 == 0) ? 4'h1 : 4'h0;
            @(negedge clk);
            bus8.req = 1;
            @(negedge clk);
            bus8.req = 0;
            for (int c = 0; c < 20 && bus8.rnd_valid !== 1'b1; c++) begin
                @(negedge clk);
            end
            vectors++;
            if (bus8.rnd_valid !== 1'b1 || bus8.rnd_out !== want) begin
                miscompares++;
                $display("[TB] FAIL no_repeat_%0d: got valid=%b out=%h, want 1 %h",
                         k, bus8.rnd_valid, bus8.rnd_out, want);
            end
            bus8.rnd_ack = 1;
            @(negedge clk);
            bus8.rnd_ack = 0;
        end
        bus8.free_run = 0;
    endtask
`endif

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_period();
        test_lockup();
        test_basic();
        test_reject();
        test_timeout();
        test_reset_mid_search();
        test_req_in_done();
`ifdef NO_REPEAT_EN
        test_no_repeat();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
